// File: rtl/writeback_pipe_stage.sv
// MEM->WB pipeline register with a valid/ready handshake, an optional second
// (skid) entry, synchronous flush, and the final writeback mux. Writes to x0
// are suppressed on the outgoing write enable.
//
// Handshake: a transfer happens on a rising CLK edge when valid and ready are
// both high on that side (Accept = ValidM & ReadyM, Retire = ValidW & ReadyW).
// Valid never waits on ready. Once raised, valid must hold with stable data
// until the transfer. ReadyM never depends on ValidM. With SKID=1, ReadyM is a
// function of registered state only, so there is no combinational path from
// ReadyW.
module writeback_pipe_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int SKID       = 1
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic                  FlushW,
  input  logic                  ValidM,
  output logic                  ReadyM,
  input  logic                  RegWriteM,
  input  logic                  MemtoRegM,
  input  logic [DATA_W-1:0]     ReadDataM,
  input  logic [DATA_W-1:0]     ALUResultM,
  input  logic [REG_ADDR_W-1:0] rdM,
  input  logic                  ReadyW,
  output logic                  ValidW,
  output logic                  RegWriteW,
  output logic                  MemtoRegW,
  output logic [DATA_W-1:0]     ReadDataW,
  output logic [DATA_W-1:0]     ALUResultW,
  output logic [DATA_W-1:0]     ResultW,
  output logic [REG_ADDR_W-1:0] rdW,
  output logic [1:0]            CountW
);

  localparam bit UseSkid = (SKID != 0);

  // The state encoding equals the occupancy, so CountW doubles as the FSM
  // state observation point.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stateT;

  stateT state;
  stateT stateNext;

  logic accept;
  logic retire;
  logic loadHeadIn;
  logic loadHeadSkid;
  logic loadSkid;

  logic                  headRegWrite;
  logic                  headMemtoReg;
  logic [DATA_W-1:0]     headReadData;
  logic [DATA_W-1:0]     headALUResult;
  logic [REG_ADDR_W-1:0] headRd;

  logic                  skidRegWrite;
  logic                  skidMemtoReg;
  logic [DATA_W-1:0]     skidReadData;
  logic [DATA_W-1:0]     skidALUResult;
  logic [REG_ADDR_W-1:0] skidRd;

  assign ValidW = (state != EMPTY);
  assign ReadyM = UseSkid ? (state != FULL) : (~ValidW | ReadyW);
  assign accept = ValidM & ReadyM;
  assign retire = ValidW & ReadyW;

  // State register; async reset empties the stage immediately.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) state <= EMPTY;
    else         state <= stateNext;
  end

  // Next state and data-load strobes; flush overrides every transition.
  always_comb begin
    stateNext    = state;
    loadHeadIn   = 1'b0;
    loadHeadSkid = 1'b0;
    loadSkid     = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          stateNext  = ONE;
          loadHeadIn = 1'b1;
        end
      end
      ONE: begin
        if (accept && retire) begin
          loadHeadIn = 1'b1;
        end else if (accept && UseSkid) begin
          stateNext = FULL;
          loadSkid  = 1'b1;
        end else if (retire) begin
          stateNext = EMPTY;
        end
      end
      FULL: begin
        if (retire) begin
          stateNext    = ONE;
          loadHeadSkid = 1'b1;
        end
      end
      default: stateNext = EMPTY;
    endcase
    if (FlushW) begin
      stateNext    = EMPTY;
      loadHeadIn   = 1'b0;
      loadHeadSkid = 1'b0;
      loadSkid     = 1'b0;
    end
  end

  // Head entry: loads from the input or from the skid entry, otherwise holds.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      headRegWrite  <= 1'b0;
      headMemtoReg  <= 1'b0;
      headReadData  <= '0;
      headALUResult <= '0;
      headRd        <= '0;
    end else if (loadHeadIn) begin
      headRegWrite  <= RegWriteM;
      headMemtoReg  <= MemtoRegM;
      headReadData  <= ReadDataM;
      headALUResult <= ALUResultM;
      headRd        <= rdM;
    end else if (loadHeadSkid) begin
      headRegWrite  <= skidRegWrite;
      headMemtoReg  <= skidMemtoReg;
      headReadData  <= skidReadData;
      headALUResult <= skidALUResult;
      headRd        <= skidRd;
    end
  end

  // Skid entry: captures the input only when the head is stalled.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      skidRegWrite  <= 1'b0;
      skidMemtoReg  <= 1'b0;
      skidReadData  <= '0;
      skidALUResult <= '0;
      skidRd        <= '0;
    end else if (loadSkid) begin
      skidRegWrite  <= RegWriteM;
      skidMemtoReg  <= MemtoRegM;
      skidReadData  <= ReadDataM;
      skidALUResult <= ALUResultM;
      skidRd        <= rdM;
    end
  end

  assign RegWriteW  = ValidW & headRegWrite & (headRd != '0);
  assign MemtoRegW  = headMemtoReg;
  assign ReadDataW  = headReadData;
  assign ALUResultW = headALUResult;
  assign rdW        = headRd;
  assign ResultW    = headMemtoReg ? headReadData : headALUResult;
  assign CountW     = state;

endmodule
